// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: mode encoding and
// slice-width derivation helpers.
package pipe_adder_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    localparam int unsigned DEFAULT_WIDTH  = 32;
    localparam int unsigned DEFAULT_STAGES = 4;

    // Bits handled by each pipeline slice.
    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return (stages == 0) ? 0 : width / stages;
    endfunction

    // Legal split: at least one slice and an even carry-chain partition.
    function automatic bit split_ok(input int unsigned width,
                                    input int unsigned stages);
        return (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One registered slice of the carry chain: adds its CHUNK bits with the
// incoming carry and forwards operands, partial result and carry downstream.
module pipe_adder_stage
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CHUNK = 8,
    parameter int unsigned POS   = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             up_valid,
    input  logic             ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] res_in,
    input  logic             carry_in,
    output logic             valid,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] res_out,
    output logic             carry_out,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned LO = POS * CHUNK;
    localparam int unsigned CW = CHUNK + 1;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic [CW-1:0]    chunk_sum;
    logic [WIDTH-1:0] res_d;
    logic             msb_carry_in;
    logic             ovf_d;
    logic             zero_d;
    logic             load;

    assign a_chunk   = a_in[LO +: CHUNK];
    assign b_chunk   = b_in[LO +: CHUNK];
    assign chunk_sum = CW'(a_chunk) + CW'(b_chunk) + CW'(carry_in);
    assign s_chunk   = chunk_sum[CHUNK-1:0];

    // Carry into the slice's top bit, recovered from that bit's sum.
    assign msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ s_chunk[CHUNK-1];
    assign ovf_d        = msb_carry_in ^ chunk_sum[CHUNK];

    always_comb begin
        res_d              = res_in;
        res_d[LO +: CHUNK] = s_chunk;
    end

    assign zero_d = (res_d == '0);
    assign load   = up_valid && ready;

    // Slice register; ovf/zero are meaningful only in the most significant slice.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid     <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            res_out   <= '0;
            carry_out <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            if (ready) begin
                valid <= up_valid;
            end
            if (load) begin
                a_out     <= a_in;
                b_out     <= b_in;
                res_out   <= res_d;
                carry_out <= chunk_sum[CHUNK];
                ovf       <= ovf_d;
                zero      <= zero_d;
            end
        end
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: STAGES registered carry-chain slices with
// valid/ready flow control, producing sum plus carry/overflow/zero flags.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

    if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
        $error("pipe_adder: STAGES must be >= 1 and divide WIDTH");
    end

    mode_e             mode;
    logic [STAGES-1:0] valid_vec;
    logic [STAGES-1:0] up_vec;
    logic [STAGES:0]   ready_vec;

    logic [WIDTH-1:0]  stage_a     [STAGES+1];
    logic [WIDTH-1:0]  stage_b     [STAGES+1];
    logic [WIDTH-1:0]  stage_res   [STAGES+1];
    logic              stage_carry [STAGES+1];
    logic              stage_ovf   [STAGES];
    logic              stage_zero  [STAGES];

    assign mode = mode_e'(sub);

    // Slice 0 sees the inverted subtrahend and a carry-in of one for a-b.
    assign stage_a[0]     = a;
    assign stage_b[0]     = (mode == MODE_SUB) ? ~b : b;
    assign stage_res[0]   = '0;
    assign stage_carry[0] = (mode == MODE_SUB);

    // Upstream valid for each slice.
    always_comb begin
        up_vec    = '0;
        up_vec[0] = in_valid;
        for (int k = 1; k < int'(STAGES); k++) begin
            up_vec[k] = valid_vec[k-1];
        end
    end

    // A slice may load when it is empty or its contents move on this cycle.
    always_comb begin
        ready_vec         = '0;
        ready_vec[STAGES] = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            ready_vec[k] = !valid_vec[k] || ready_vec[k+1];
        end
    end

    assign in_ready = ready_vec[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_adder_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .POS   (k)
        ) u_stage (
            .clk       (clk),
            .rstn      (rstn),
            .up_valid  (up_vec[k]),
            .ready     (ready_vec[k]),
            .a_in      (stage_a[k]),
            .b_in      (stage_b[k]),
            .res_in    (stage_res[k]),
            .carry_in  (stage_carry[k]),
            .valid     (valid_vec[k]),
            .a_out     (stage_a[k+1]),
            .b_out     (stage_b[k+1]),
            .res_out   (stage_res[k+1]),
            .carry_out (stage_carry[k+1]),
            .ovf       (stage_ovf[k]),
            .zero      (stage_zero[k])
        );
    end

    assign out_valid = valid_vec[STAGES-1];
    assign sum       = stage_res[STAGES];
    assign cout      = stage_carry[STAGES];
    assign ovf       = stage_ovf[STAGES-1];
    assign zero      = stage_zero[STAGES-1];

endmodule
